pe_fp_mac_pipe: RTL and testbench
=================================

// Module: pe_fp_mac_pipe
// PURPOSE
//  Parametrised, pipelined floating-point multiply-accumulate processing element for the systolic array.
//  Forwards A/B operands with valid to the east/south neighbours.
//  Accumulates a*b products over a programmable dot-product length k_len and emits the tile result with a one-cycle strobe.
//  Replaces the unpipelined single-precision PE; accumulation is gated by valid and tile-delimited.
// PARAMETERS
//  EXP_W    8   exponent field width; bias = 2^(EXP_W-1)-1
//  MAN_W    23  stored mantissa width (hidden bit implicit); word W = 1+EXP_W+MAN_W
//  CNT_W    16  width of k_len and the internal element counter
// PORTS
//  clk       in   1      rising-edge clock
//  reset     in   1      asynchronous, active-high; clears all state
//  in_valid  in   1      in_a/in_b carry a valid element this cycle
//  in_a      in   W      operand A (row stream)
//  in_b      in   W      operand B (column stream)
//  k_len     in   CNT_W  elements per tile; sampled on the first valid element of a tile; 0 treated as 1
//  out_valid out  1      registered copy of in_valid (to neighbour)
//  out_a     out  W      registered copy of in_a
//  out_b     out  W      registered copy of in_b
//  out_c     out  W      last completed tile sum; holds until next completion
//  c_valid   out  1      1-cycle pulse: out_c updated this cycle
//  busy      out  1      tile in progress or products in flight
// BEHAVIOUR
//  Reset
//   - All outputs 0; accumulator, counter, pipeline valids 0.
//   - Reset mid-tile discards the partial sum; the next valid starts a new tile.
//  Forwarding
//   - out_a/out_b/out_valid <= in_a/in_b/in_valid every cycle, regardless of valid (1-cycle latency).
//  Stage 1 (cycle t+1)
//   - p_q <= fp_mul(in_a,in_b); p_vld <= in_valid.
//   - p_last <= (element index == k_len_eff-1).
//   - Counter increments only on in_valid and wraps to 0 after the last element.
//   - Bubbles (in_valid=0) neither count nor accumulate.
//  Stage 2 (cycle t+2)
//   - On p_vld: sum = fp_add(first ? +0 : acc, p_q).
//   - If p_last: out_c <= sum, c_valid <= 1, acc <= +0. Otherwise acc <= sum.
//   - Latency: last element in at cycle t -> c_valid=1 at t+2.
//   - Back-to-back tiles at full rate are supported, including k_len=1 (c_valid every cycle).
//  Multiply
//   - sign = xor of signs; mantissa product (MAN_W+1)^2.
//   - Normalise by 1 bit; truncate (no rounding).
//   - exp = ea+eb-bias+norm.
//  Add
//   - Larger magnitude selected (exponent, then mantissa); smaller aligned by right shift.
//   - Shift >= MAN_W+2 -> contributes 0.
//   - Carry -> shift right, exp+1.
//   - Otherwise normalise with a leading-zero-count priority encoder (no loops); truncate.
//   - Exact cancellation -> +0.
//  Special values
//   - exp field 0 = zero (denormals flushed, inputs and results).
//   - exp field all-ones = signed infinity (NaN not generated).
//   - Overflow saturates to signed inf; underflow -> +0.
//   - inf + (-inf) -> +inf.
//  busy = (counter!=0) | p_vld | stage-2 valid.
// STRUCTURE
//  Package pe_fp_pkg
//   - Derived widths W, BIAS, EXP_MAX.
//   - Functions fp_is_zero, fp_is_inf.
//   - Constant FP_POS_ZERO, FP_INF(sign).
//  Sub-module fp_add_core
//   - Combinational align/add/LZC-normalise.
//   - Reused by future reduction trees.
//   - Multiply stays inline.
// TESTING (EXP_W=8, MAN_W=23)
//  - Dot product: k_len=4, A=3F800000,40000000,40400000,40800000, B=3F800000 x4, consecutive
//    -> out_c=41200000 (10.0), c_valid 2 cycles after last element, single pulse.
//  - Cancellation: k_len=2, (40000000*40400000)+(C0000000*40400000)
//    -> out_c=00000000; zero input 00000000*7F000000 -> product 0.
//  - Overflow: k_len=1, 7F000000*7F000000 -> 7F800000; FF000000*7F000000 -> FF800000.
//  - Bubbles: k_len=3, valid pattern 1,0,0,1,0,1 with 3F800000*3F800000
//    -> single c_valid, out_c=40400000; out_a/out_b/out_valid track inputs delayed 1 cycle.
//  - Back-to-back: k_len=1, 8 consecutive valids 40000000*40000000
//    -> c_valid high 8 consecutive cycles, out_c=40800000 each.
//  - Reset mid-tile: k_len=4, two valid elements, assert reset asynchronously
//    -> all outputs 0 immediately.
//    Then a full 4-element tile of 1.0*1.0 -> out_c=40800000 (no residue).

Source files
------------

// File: rtl/pe_fp_pkg.sv
// Shared floating-point format definitions for the systolic-array processing elements.
// The FP_* widths describe the default format; modules derive their own copies from parameters.
package pe_fp_pkg;

    localparam int FP_EXP_W   = 8;
    localparam int FP_MAN_W   = 23;
    localparam int FP_CNT_W   = 16;
    localparam int FP_W       = 1 + FP_EXP_W + FP_MAN_W;
    localparam int FP_BIAS    = (1 << (FP_EXP_W - 1)) - 1;
    localparam int FP_EXP_MAX = (1 << FP_EXP_W) - 1;

    localparam logic [FP_W-1:0] FP_POS_ZERO = '0;

    function automatic logic [FP_W-1:0] FP_INF(input logic sign);
        return {sign, {FP_EXP_W{1'b1}}, {FP_MAN_W{1'b0}}};
    endfunction

    // Exponent-field tests take a zero-extended field so any EXP_W up to 32 can use them.
    function automatic logic fp_is_zero(input logic [31:0] exp_f);
        return exp_f == 32'd0;
    endfunction

    function automatic logic fp_is_inf(input logic [31:0] exp_f, input int exp_max);
        return exp_f == 32'(exp_max);
    endfunction

endpackage

// File: rtl/fp_add_core.sv
// Combinational floating-point adder: magnitude-ordered align, add/subtract, LZC normalise.
// Truncating, denormals flushed, saturating to signed infinity.
module fp_add_core
    import pe_fp_pkg::*;
#(
    parameter int EXP_W = FP_EXP_W,
    parameter int MAN_W = FP_MAN_W
)(
    input  logic [EXP_W+MAN_W:0] a_i,
    input  logic [EXP_W+MAN_W:0] b_i,
    output logic [EXP_W+MAN_W:0] sum_o
);

    localparam int W       = 1 + EXP_W + MAN_W;
    localparam int EXP_MAX = (1 << EXP_W) - 1;
    localparam int NRM_W   = MAN_W + 2;          // hidden + mantissa + one guard bit
    localparam int SIG_W   = NRM_W + 1;          // plus carry
    localparam int LZC_K   = $clog2(NRM_W);
    localparam int LZC_L   = 1 << LZC_K;
    localparam logic [W-2:0] INF_MAG = {{EXP_W{1'b1}}, {MAN_W{1'b0}}};

    logic             sa, sb;
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] ma, mb;
    logic             a_zero, b_zero, a_inf, b_inf;

    assign {sa, ea, ma} = a_i;
    assign {sb, eb, mb} = b_i;
    assign a_zero = fp_is_zero(32'(ea));
    assign b_zero = fp_is_zero(32'(eb));
    assign a_inf  = fp_is_inf(32'(ea), EXP_MAX);
    assign b_inf  = fp_is_inf(32'(eb), EXP_MAX);

    logic             a_big;
    logic             s_big, s_small;
    logic [EXP_W-1:0] e_big, e_small, shamt;
    logic [MAN_W-1:0] m_big, m_small;
    logic [SIG_W-1:0] sig_big, sig_small, sig_sum;

    assign a_big = {ea, ma} >= {eb, mb};
    assign {s_big, e_big, m_big}       = a_big ? a_i : b_i;
    assign {s_small, e_small, m_small} = a_big ? b_i : a_i;
    assign shamt     = e_big - e_small;
    assign sig_big   = {1'b0, 1'b1, m_big, 1'b0};
    assign sig_small = (int'(shamt) >= NRM_W) ? '0 : ({1'b0, 1'b1, m_small, 1'b0} >> shamt);
    assign sig_sum   = (s_big == s_small) ? sig_big + sig_small : sig_big - sig_small;

    // Leading-zero count as a log-depth shifter: each stage tests the top 2^k bits.
    logic [LZC_L-1:0] nrm_in, nrm_out;
    logic [LZC_K-1:0] lz;

    assign nrm_in = LZC_L'(sig_sum[NRM_W-1:0]) << (LZC_L - NRM_W);

    for (genvar g = 0; g < LZC_K; g++) begin : g_lzc
        localparam int SH = 1 << (LZC_K - 1 - g);
        logic [LZC_L-1:0] v_in, v_out;
        logic             z;
        if (g == 0) begin : g_first
            assign v_in = nrm_in;
        end else begin : g_next
            assign v_in = g_lzc[g-1].v_out;
        end
        assign z     = ~|v_in[LZC_L-1 -: SH];
        assign v_out = z ? (v_in << SH) : v_in;
    end

    for (genvar g = 0; g < LZC_K; g++) begin : g_lz_bits
        assign lz[LZC_K-1-g] = g_lzc[g].z;
    end

    assign nrm_out = g_lzc[LZC_K-1].v_out;

    logic unused_nrm_bits;
    assign unused_nrm_bits = ^{nrm_out[LZC_L-1], nrm_out[LZC_L-MAN_W-2:0]};

    int exp_c;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path infers a latch.
        sum_o = '0;
        exp_c = 0;
        if (a_inf && b_inf) begin
            sum_o = {sa & sb, INF_MAG};
        end else if (a_inf) begin
            sum_o = {sa, INF_MAG};
        end else if (b_inf) begin
            sum_o = {sb, INF_MAG};
        end else if (a_zero) begin
            sum_o = b_zero ? '0 : b_i;
        end else if (b_zero) begin
            sum_o = a_i;
        end else if (sig_sum[SIG_W-1]) begin
            exp_c = int'(e_big) + 1;
            sum_o = (exp_c >= EXP_MAX) ? {s_big, INF_MAG}
                                       : {s_big, EXP_W'(exp_c), sig_sum[SIG_W-2:2]};
        end else if (sig_sum[NRM_W-1:0] != '0) begin
            exp_c = int'(e_big) - int'(lz);
            sum_o = (exp_c <= 0) ? '0 : {s_big, EXP_W'(exp_c), nrm_out[LZC_L-2 -: MAN_W]};
        end
    end

endmodule

// File: rtl/pe_fp_mac_pipe.sv
// Pipelined FP multiply-accumulate PE: forwards operands east/south, multiplies in stage 1,
// accumulates per tile of k_len valid elements in stage 2 and strobes the finished sum.
module pe_fp_mac_pipe
    import pe_fp_pkg::*;
#(
    parameter int EXP_W = FP_EXP_W,
    parameter int MAN_W = FP_MAN_W,
    parameter int CNT_W = FP_CNT_W
)(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [EXP_W+MAN_W:0] in_a,
    input  logic [EXP_W+MAN_W:0] in_b,
    input  logic [CNT_W-1:0]     k_len,
    output logic                 out_valid,
    output logic [EXP_W+MAN_W:0] out_a,
    output logic [EXP_W+MAN_W:0] out_b,
    output logic [EXP_W+MAN_W:0] out_c,
    output logic                 c_valid,
    output logic                 busy
);

    localparam int W       = 1 + EXP_W + MAN_W;
    localparam int SIG_W   = MAN_W + 1;
    localparam int BIAS    = (1 << (EXP_W - 1)) - 1;
    localparam int EXP_MAX = (1 << EXP_W) - 1;
    localparam logic [W-2:0] INF_MAG = {{EXP_W{1'b1}}, {MAN_W{1'b0}}};

    // ---------------- multiply (inline, truncating) ----------------
    logic               sa, sb;
    logic [EXP_W-1:0]   ea, eb;
    logic [MAN_W-1:0]   ma, mb;
    logic [2*SIG_W-1:0] prod;
    logic [MAN_W-1:0]   mul_man;
    logic [W-1:0]       mul_res;
    int                 mul_exp;

    assign {sa, ea, ma} = in_a;
    assign {sb, eb, mb} = in_b;
    assign prod = (2*SIG_W)'({1'b1, ma}) * (2*SIG_W)'({1'b1, mb});

    logic unused_prod_bits;
    assign unused_prod_bits = ^prod[MAN_W-1:0];

    always_comb begin
        mul_man = prod[2*SIG_W-1] ? prod[2*SIG_W-2 -: MAN_W] : prod[2*SIG_W-3 -: MAN_W];
        mul_exp = int'(ea) + int'(eb) - BIAS + (prod[2*SIG_W-1] ? 1 : 0);
        mul_res = {sa ^ sb, EXP_W'(mul_exp), mul_man};
        // Zero operands win over infinity so inf*0 yields +0 rather than a NaN.
        if (fp_is_zero(32'(ea)) || fp_is_zero(32'(eb))) begin
            mul_res = '0;
        end else if (fp_is_inf(32'(ea), EXP_MAX) || fp_is_inf(32'(eb), EXP_MAX)) begin
            mul_res = {sa ^ sb, INF_MAG};
        end else if (mul_exp >= EXP_MAX) begin
            mul_res = {sa ^ sb, INF_MAG};
        end else if (mul_exp <= 0) begin
            mul_res = '0;
        end
    end

    // ---------------- tile element counter ----------------
    logic [CNT_W-1:0] cnt_q, cnt_d, klen_q, klen_d, k_eff;
    logic             first, last;

    always_comb begin
        first  = (cnt_q == '0);
        k_eff  = first ? ((k_len == '0) ? CNT_W'(1) : k_len) : klen_q;
        last   = (cnt_q == k_eff - CNT_W'(1));
        cnt_d  = cnt_q;
        klen_d = klen_q;
        if (in_valid) begin
            cnt_d = last ? '0 : cnt_q + CNT_W'(1);
            if (first) klen_d = k_eff;
        end
    end

    // ---------------- stage 2 accumulate ----------------
    logic [W-1:0] p_q, acc_q, acc_d, out_c_q, out_c_d, add_a, add_sum;
    logic         p_vld_q, p_last_q, p_first_q, s2_vld_q, c_valid_q, c_valid_d;

    assign add_a = p_first_q ? '0 : acc_q;

    fp_add_core #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_add (
        .a_i   (add_a),
        .b_i   (p_q),
        .sum_o (add_sum)
    );

    always_comb begin
        acc_d     = acc_q;
        out_c_d   = out_c_q;
        c_valid_d = 1'b0;
        if (p_vld_q) begin
            if (p_last_q) begin
                out_c_d   = add_sum;
                c_valid_d = 1'b1;
                acc_d     = '0;
            end else begin
                acc_d = add_sum;
            end
        end
    end

    // ---------------- registers ----------------
    logic         out_valid_q;
    logic [W-1:0] out_a_q, out_b_q;

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            out_valid_q <= 1'b0;
            out_a_q     <= '0;
            out_b_q     <= '0;
            cnt_q       <= '0;
            klen_q      <= '0;
            p_q         <= '0;
            p_vld_q     <= 1'b0;
            p_last_q    <= 1'b0;
            p_first_q   <= 1'b0;
            s2_vld_q    <= 1'b0;
            acc_q       <= '0;
            out_c_q     <= '0;
            c_valid_q   <= 1'b0;
        end else begin
            out_valid_q <= in_valid;
            out_a_q     <= in_a;
            out_b_q     <= in_b;
            cnt_q       <= cnt_d;
            klen_q      <= klen_d;
            p_q         <= mul_res;
            p_vld_q     <= in_valid;
            p_last_q    <= in_valid & last;
            p_first_q   <= first;
            s2_vld_q    <= p_vld_q;
            acc_q       <= acc_d;
            out_c_q     <= out_c_d;
            c_valid_q   <= c_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_a     = out_a_q;
    assign out_b     = out_b_q;
    assign out_c     = out_c_q;
    assign c_valid   = c_valid_q;
    assign busy      = (cnt_q != '0) | p_vld_q | s2_vld_q;

endmodule

// File: tb/tb_pe_fp_mac_pipe.sv
// Directed bench for pe_fp_mac_pipe: dot product, cancellation, overflow, bubbles,
// back-to-back single-element tiles and asynchronous reset mid-tile.
module tb_pe_fp_mac_pipe;
    import pe_fp_pkg::*;

    localparam int W = FP_W;

    logic                clk = 1'b0;
    logic                reset;
    logic                in_valid;
    logic [W-1:0]        in_a, in_b;
    logic [FP_CNT_W-1:0] k_len;
    logic                out_valid;
    logic [W-1:0]        out_a, out_b, out_c;
    logic                c_valid, busy;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    pe_fp_mac_pipe dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_a      (in_a),
        .in_b      (in_b),
        .k_len     (k_len),
        .out_valid (out_valid),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_c     (out_c),
        .c_valid   (c_valid),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are checked right after, away from the rising edge.
    task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        in_valid = v;
        in_a     = a;
        in_b     = b;
    endtask

    task automatic idle();
        drive(1'b0, '0, '0);
    endtask

    logic [W-1:0] dot_a [4];
    logic         bub_v [6];
    logic [W-1:0] bub_a [6];
    logic [W-1:0] bub_b [6];

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "bench did not finish");
    end

    initial begin
        dot_a = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000};
        bub_v = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 6; i++) begin
            bub_a[i] = bub_v[i] ? 32'h3F80_0000 : 32'h1234_0000 + W'(i);
            bub_b[i] = bub_v[i] ? 32'h3F80_0000 : 32'h5678_0000 + W'(i);
        end

        // ---- reset state ----
        reset = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; k_len = 16'd4;
        @(negedge clk); @(negedge clk);
        check_bit("rst_out_valid", out_valid, 1'b0);
        check("rst_out_a", out_a, '0);
        check("rst_out_c", out_c, '0);
        check_bit("rst_c_valid", c_valid, 1'b0);
        check_bit("rst_busy", busy, 1'b0);
        reset = 1'b0;

        // ---- dot product 1*1 + 2*1 + 3*1 + 4*1 = 10 ----
        k_len = 16'd4;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, dot_a[i], 32'h3F80_0000);
            if (i > 0) check("dot_fwd_a", out_a, dot_a[i-1]);
            check_bit("dot_cv_early", c_valid, 1'b0);
        end
        idle();
        check_bit("dot_cv_t1", c_valid, 1'b0);
        check_bit("dot_busy", busy, 1'b1);
        check("dot_fwd_last", out_a, 32'h4080_0000);
        idle();
        check_bit("dot_cv_t2", c_valid, 1'b1);
        check("dot_sum", out_c, 32'h4120_0000);
        idle();
        check_bit("dot_cv_single", c_valid, 1'b0);
        check("dot_hold", out_c, 32'h4120_0000);
        check_bit("dot_idle_busy", busy, 1'b0);

        // ---- cancellation 2*3 + (-2)*3 = +0 ----
        k_len = 16'd2;
        drive(1'b1, 32'h4000_0000, 32'h4040_0000);
        drive(1'b1, 32'hC000_0000, 32'h4040_0000);
        idle();
        check_bit("cancel_cv_t1", c_valid, 1'b0);
        idle();
        check_bit("cancel_cv_t2", c_valid, 1'b1);
        check("cancel_sum", out_c, 32'h0000_0000);

        // ---- overflow and zero operand, k_len=1 ----
        k_len = 16'd1;
        drive(1'b1, 32'h7F00_0000, 32'h7F00_0000);
        drive(1'b1, 32'hFF00_0000, 32'h7F00_0000);
        drive(1'b1, 32'h0000_0000, 32'h7F00_0000);
        check("ovf_pos", out_c, 32'h7F80_0000);
        idle();
        check("ovf_neg", out_c, 32'hFF80_0000);
        idle();
        check_bit("zero_cv", c_valid, 1'b1);
        check("zero_prod", out_c, 32'h0000_0000);
        idle();
        check_bit("zero_cv_end", c_valid, 1'b0);

        // ---- bubbles: valid pattern 1,0,0,1,0,1 of 1*1, k_len=3 ----
        k_len = 16'd3;
        for (int i = 0; i < 6; i++) begin
            drive(bub_v[i], bub_a[i], bub_b[i]);
            if (i > 0) begin
                check_bit("bub_fwd_valid", out_valid, bub_v[i-1]);
                check("bub_fwd_a", out_a, bub_a[i-1]);
                check("bub_fwd_b", out_b, bub_b[i-1]);
            end
            check_bit("bub_cv_early", c_valid, 1'b0);
        end
        idle();
        check_bit("bub_fwd_valid_last", out_valid, 1'b1);
        check_bit("bub_cv_t1", c_valid, 1'b0);
        idle();
        check_bit("bub_cv_t2", c_valid, 1'b1);
        check("bub_sum", out_c, 32'h4040_0000);
        check_bit("bub_fwd_idle", out_valid, 1'b0);
        idle();
        check_bit("bub_cv_single", c_valid, 1'b0);

        // ---- back-to-back k_len=1: eight 2*2 products ----
        k_len = 16'd1;
        for (int j = 0; j < 11; j++) begin
            if (j < 8) drive(1'b1, 32'h4000_0000, 32'h4000_0000);
            else       idle();
            check_bit("b2b_cv", c_valid, (j >= 2) && (j < 10));
            if ((j >= 2) && (j < 10)) check("b2b_sum", out_c, 32'h4080_0000);
        end

        // ---- asynchronous reset mid-tile ----
        k_len = 16'd4;
        drive(1'b1, 32'h3F80_0000, 32'h3F80_0000);
        drive(1'b1, 32'h3F80_0000, 32'h3F80_0000);
        #2 reset = 1'b1;
        #1;
        check_bit("arst_out_valid", out_valid, 1'b0);
        check("arst_out_a", out_a, '0);
        check("arst_out_b", out_b, '0);
        check("arst_out_c", out_c, '0);
        check_bit("arst_c_valid", c_valid, 1'b0);
        check_bit("arst_busy", busy, 1'b0);
        @(negedge clk);
        reset = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h3F80_0000, 32'h3F80_0000);
            check_bit("post_rst_cv_early", c_valid, 1'b0);
        end
        idle();
        check_bit("post_rst_cv_t1", c_valid, 1'b0);
        idle();
        check_bit("post_rst_cv_t2", c_valid, 1'b1);
        check("post_rst_sum", out_c, 32'h4080_0000);
        idle();
        check_bit("post_rst_cv_end", c_valid, 1'b0);
        check_bit("post_rst_busy", busy, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
